// File: rtl/data_mem_if.sv
// data_mem_if: request/response bus between the load/store stage and data_mem.
interface data_mem_if #(
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH_LOG2 = 10
);
   localparam int OFF_W      = $clog2(DATA_WIDTH / 8);
   localparam int ADDR_WIDTH = DEPTH_LOG2 + OFF_W;
   logic                  req_valid_i;
   logic                  req_ready_o;
   logic                  req_we_i;
   logic [ADDR_WIDTH-1:0] req_addr_i;
   logic [2:0]            req_wid_i;
   logic [DATA_WIDTH-1:0] req_wdata_i;
   logic                  resp_valid_o;
   logic [DATA_WIDTH-1:0] resp_rdata_o;
   logic                  resp_err_o;
   logic                  init_done_o;
   modport master (
      output req_valid_i, req_we_i, req_addr_i, req_wid_i, req_wdata_i,
      input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, init_done_o
   );
   modport slave (
      input  req_valid_i, req_we_i, req_addr_i, req_wid_i, req_wdata_i,
      output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, init_done_o
   );
endinterface

// File: rtl/data_mem.sv
// data_mem: byte-addressed load/store memory with zero sweep after reset.
// Optional DATA_MEM_ALIGN_CHECK_EN turns misaligned accesses into errors instead of aligning down.
module data_mem #(
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH_LOG2 = 10
) (
   input logic       clk,
   input logic       rst_n,
   data_mem_if.slave bus
);
   localparam int OFF_W      = $clog2(DATA_WIDTH / 8);
   localparam int ADDR_WIDTH = DEPTH_LOG2 + OFF_W;
   localparam int NB         = DATA_WIDTH / 8;
   localparam int DEPTH      = 1 << DEPTH_LOG2;
   typedef enum logic {S_INIT, S_RUN} state_t;
   state_t                  r_state, w_state_nx;
   logic [DEPTH_LOG2-1:0]   r_idx, w_idx_nx;
   logic                    w_ready;
   logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
   logic                    r_resp_valid, r_resp_err;
   logic [DATA_WIDTH-1:0]   r_rdata;
   logic [DEPTH_LOG2-1:0]   w_word;
   logic [OFF_W-1:0]        w_off, w_mask, w_off_al;
   logic [2:0]              w_mask3;
   logic [1:0]              w_sz;
   logic                    w_uns, w_mis, w_err, w_acc;
   logic [NB-1:0]           w_base, w_be;
   logic [DATA_WIDTH-1:0]   w_rd_sh, w_ld, w_wsh;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_state <= S_INIT;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nx;
         r_idx   <= w_idx_nx;
      end
   always_comb begin
      w_state_nx = r_state;
      w_idx_nx   = r_idx;
      w_ready    = r_state == S_RUN;
      if (r_state == S_INIT) begin
         w_idx_nx   = r_idx + 1'b1;
         w_state_nx = &r_idx ? S_RUN : S_INIT;
      end
   end
   assign w_word   = bus.req_addr_i[ADDR_WIDTH-1:OFF_W];
   assign w_off    = bus.req_addr_i[OFF_W-1:0];
   assign w_sz     = bus.req_wid_i[1:0];
   assign w_uns    = bus.req_wid_i[2];
   assign w_mask3  = w_sz == 2'd0 ? 3'd0 : w_sz == 2'd1 ? 3'd1 : w_sz == 2'd2 ? 3'd3 : 3'd7;
   assign w_mask   = w_mask3[OFF_W-1:0];
   assign w_off_al = w_off & ~w_mask;
`ifdef DATA_MEM_ALIGN_CHECK_EN
   assign w_mis = |(w_off & w_mask);
`else
   assign w_mis = 1'b0;
`endif
   // 32-bit build has no D, and WU would be a plain W there
   assign w_err = (bus.req_wid_i == 3'b111) | (bus.req_we_i & w_uns) | w_mis |
                  ((DATA_WIDTH == 32) && (bus.req_wid_i == 3'b011 || bus.req_wid_i == 3'b110));
   assign w_acc = bus.req_valid_i & w_ready;
   assign w_rd_sh = r_mem[w_word] >> {w_off_al, 3'b000};
   assign w_ld = w_sz == 2'd0 ? (w_uns ? DATA_WIDTH'(w_rd_sh[7:0])  : DATA_WIDTH'($signed(w_rd_sh[7:0]))) :
                 w_sz == 2'd1 ? (w_uns ? DATA_WIDTH'(w_rd_sh[15:0]) : DATA_WIDTH'($signed(w_rd_sh[15:0]))) :
                 w_sz == 2'd2 ? (w_uns ? DATA_WIDTH'(w_rd_sh[31:0]) : DATA_WIDTH'($signed(w_rd_sh[31:0]))) :
                 w_rd_sh;
   assign w_base = w_sz == 2'd0 ? NB'(1) : w_sz == 2'd1 ? NB'(3) : w_sz == 2'd2 ? NB'(15) : '1;
   assign w_be   = w_base << w_off_al;
   assign w_wsh  = bus.req_wdata_i << {w_off_al, 3'b000};
   always_ff @(posedge clk)
      if (r_state == S_INIT)
         r_mem[r_idx] <= '0;
      else if (w_acc && bus.req_we_i && !w_err)
         for (int b = 0; b < NB; b++)
            if (w_be[b]) r_mem[w_word][8*b +: 8] <= w_wsh[8*b +: 8];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         r_rdata      <= '0;
      end else begin
         r_resp_valid <= w_acc;
         r_resp_err   <= w_acc & w_err;
         r_rdata      <= (w_acc && !bus.req_we_i && !w_err) ? w_ld : '0;
      end
   assign bus.req_ready_o  = w_ready;
   assign bus.init_done_o  = w_ready;
   assign bus.resp_valid_o = r_resp_valid;
   assign bus.resp_err_o   = r_resp_err;
   assign bus.resp_rdata_o = r_rdata;
endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: directed vector table plus reset/back-to-back sequences for data_mem (64-bit, 16 words).
module tb_data_mem;
   logic clk = 1'b0;
   logic rst_n;
   int   n_pass = 0;
   int   n_tot  = 0;
   always #5 clk = ~clk;
   data_mem_if #(.DATA_WIDTH(64), .DEPTH_LOG2(4)) bus ();
   data_mem #(.DATA_WIDTH(64), .DEPTH_LOG2(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   typedef struct {
      logic        we;
      logic [6:0]  addr;
      logic [2:0]  wid;
      logic [63:0] wdata;
      logic        err;
      logic [63:0] rdata;
   } vec_t;
   vec_t vecs[$];
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", nm, act, exp);
   endtask
   task automatic do_req(input logic we, input logic [6:0] a, input logic [2:0] w, input logic [63:0] d,
                         output logic rv, output logic [63:0] rd, output logic er);
      bus.req_valid_i = 1'b1;
      bus.req_we_i    = we;
      bus.req_addr_i  = a;
      bus.req_wid_i   = w;
      bus.req_wdata_i = d;
      @(posedge clk);
      @(negedge clk);
      rv = bus.resp_valid_o;
      rd = bus.resp_rdata_o;
      er = bus.resp_err_o;
      bus.req_valid_i = 1'b0;
   endtask
   task automatic wait_sweep();
      int n = 0;
      while (!bus.req_ready_o && n < 100) begin
         @(posedge clk);
         @(negedge clk);
         n++;
      end
      chk("sweep_len", 64'(n), 64'd16);
      chk("init_done", 64'(bus.init_done_o), 64'd1);
   endtask
   initial begin
      logic        rv, er, mis_err;
      logic [63:0] rd, mis_rd;
      int          pulses;
`ifdef DATA_MEM_ALIGN_CHECK_EN
      mis_err = 1'b1;
      mis_rd  = 64'h0;
`else
      mis_err = 1'b0;
      mis_rd  = 64'hFFFF_FFFF_8BAD_F00D;
`endif
      vecs.push_back(vec_t'{1'b0, 7'h08, 3'b011, 64'h0, 1'b0, 64'h0});
      vecs.push_back(vec_t'{1'b1, 7'h10, 3'b011, 64'h8877_6655_4433_2211, 1'b0, 64'h0});
      vecs.push_back(vec_t'{1'b1, 7'h13, 3'b000, 64'hF0, 1'b0, 64'h0});
      vecs.push_back(vec_t'{1'b0, 7'h10, 3'b011, 64'h0, 1'b0, 64'h8877_6655_F033_2211});
      vecs.push_back(vec_t'{1'b0, 7'h13, 3'b000, 64'h0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF0});
      vecs.push_back(vec_t'{1'b0, 7'h13, 3'b100, 64'h0, 1'b0, 64'hF0});
      vecs.push_back(vec_t'{1'b1, 7'h30, 3'b100, 64'hAA, 1'b1, 64'h0});
      vecs.push_back(vec_t'{1'b0, 7'h30, 3'b011, 64'h0, 1'b0, 64'h0});
      vecs.push_back(vec_t'{1'b1, 7'h30, 3'b010, 64'h8BAD_F00D, 1'b0, 64'h0});
      vecs.push_back(vec_t'{1'b0, 7'h31, 3'b010, 64'h0, mis_err, mis_rd});
      vecs.push_back(vec_t'{1'b0, 7'h30, 3'b110, 64'h0, 1'b0, 64'h8BAD_F00D});
      vecs.push_back(vec_t'{1'b0, 7'h32, 3'b001, 64'h0, 1'b0, 64'hFFFF_FFFF_FFFF_8BAD});
      vecs.push_back(vec_t'{1'b1, 7'h36, 3'b001, 64'h1234, 1'b0, 64'h0});
      vecs.push_back(vec_t'{1'b0, 7'h30, 3'b011, 64'h0, 1'b0, 64'h1234_0000_8BAD_F00D});
      vecs.push_back(vec_t'{1'b0, 7'h10, 3'b111, 64'h0, 1'b1, 64'h0});
      vecs.push_back(vec_t'{1'b0, 7'h78, 3'b011, 64'h0, 1'b0, 64'h0});
      vecs.push_back(vec_t'{1'b1, 7'h78, 3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h0});
      vecs.push_back(vec_t'{1'b0, 7'h7C, 3'b110, 64'h0, 1'b0, 64'hFFFF_FFFF});
      vecs.push_back(vec_t'{1'b0, 7'h7E, 3'b101, 64'h0, 1'b0, 64'hFFFF});
      rst_n           = 1'b0;
      bus.req_valid_i = 1'b0;
      bus.req_we_i    = 1'b0;
      bus.req_addr_i  = '0;
      bus.req_wid_i   = '0;
      bus.req_wdata_i = '0;
      repeat (3) @(negedge clk);
      chk("rst_ready", 64'(bus.req_ready_o), 64'd0);
      chk("rst_resp_valid", 64'(bus.resp_valid_o), 64'd0);
      chk("rst_rdata", bus.resp_rdata_o, 64'd0);
      chk("rst_err", 64'(bus.resp_err_o), 64'd0);
      chk("rst_init_done", 64'(bus.init_done_o), 64'd0);
      rst_n = 1'b1;
      wait_sweep();
      for (int i = 0; i < vecs.size(); i++) begin
         do_req(vecs[i].we, vecs[i].addr, vecs[i].wid, vecs[i].wdata, rv, rd, er);
         chk($sformatf("v%0d_valid", i), 64'(rv), 64'd1);
         chk($sformatf("v%0d_err", i), 64'(er), 64'(vecs[i].err));
         chk($sformatf("v%0d_rdata", i), rd, vecs[i].rdata);
      end
      @(negedge clk);
      chk("pulse_one_cycle", 64'(bus.resp_valid_o), 64'd0);
      pulses = 0;
      do_req(1'b1, 7'h20, 3'b011, 64'h1111_2222_3333_4444, rv, rd, er);
      pulses += int'(rv);
      do_req(1'b1, 7'h28, 3'b011, 64'h5555_6666_7777_8888, rv, rd, er);
      pulses += int'(rv);
      do_req(1'b0, 7'h20, 3'b011, 64'h0, rv, rd, er);
      pulses += int'(rv);
      chk("b2b_ld0", rd, 64'h1111_2222_3333_4444);
      do_req(1'b0, 7'h28, 3'b011, 64'h0, rv, rd, er);
      pulses += int'(rv);
      chk("b2b_ld1", rd, 64'h5555_6666_7777_8888);
      chk("b2b_pulses", 64'(pulses), 64'd4);
      @(negedge clk);
      bus.req_valid_i = 1'b1;
      bus.req_we_i    = 1'b0;
      bus.req_addr_i  = 7'h10;
      bus.req_wid_i   = 3'b011;
      @(posedge clk);
      #1;
      chk("mid_valid", 64'(bus.resp_valid_o), 64'd1);
      chk("mid_rdata", bus.resp_rdata_o, 64'h8877_6655_F033_2211);
      rst_n = 1'b0;
      #1;
      chk("mid_valid_drop", 64'(bus.resp_valid_o), 64'd0);
      chk("mid_rdata_clr", bus.resp_rdata_o, 64'd0);
      bus.req_valid_i = 1'b0;
      @(negedge clk);
      chk("mid_ready_low", 64'(bus.req_ready_o), 64'd0);
      rst_n = 1'b1;
      wait_sweep();
      do_req(1'b0, 7'h10, 3'b011, 64'h0, rv, rd, er);
      chk("post_rst_valid", 64'(rv), 64'd1);
      chk("post_rst_rdata", rd, 64'd0);
      do_req(1'b0, 7'h30, 3'b011, 64'h0, rv, rd, er);
      chk("post_rst_rdata30", rd, 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
